// File: rtl/fft_reader_pkg.sv
// Shared constants and FSM encoding for the FFT energy reader.
package fft_reader_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned ACC_W    = 48;
  localparam int unsigned N_BINS   = 1 << ADDR_W;
  localparam int unsigned LAST_BIN = N_BINS - 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    ACCUM      = 2'd2,
    FLUSH      = 2'd3
  } state_t;

endpackage

// File: rtl/fft_energy_reader_mag_sq_pipe.sv
// mag_sq_pipe: three-stage |X|^2 pipeline carrying valid and bin index alongside.
module mag_sq_pipe #(
  parameter int unsigned DATA_W = fft_reader_pkg::DATA_W,
  parameter int unsigned ADDR_W = fft_reader_pkg::ADDR_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        in_idx,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  output logic [ADDR_W-1:0]        out_idx,
  output logic [2*DATA_W:0]        out_mag
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic                     s1_valid;
  logic [ADDR_W-1:0]        s1_idx;
  logic signed [DATA_W-1:0] s1_re;
  logic signed [DATA_W-1:0] s1_im;
  logic                     s2_valid;
  logic [ADDR_W-1:0]        s2_idx;
  logic [PROD_W-1:0]        s2_re_sq;
  logic [PROD_W-1:0]        s2_im_sq;
  logic signed [PROD_W-1:0] re_ext_c;
  logic signed [PROD_W-1:0] im_ext_c;
  logic signed [PROD_W-1:0] re_sq_c;
  logic signed [PROD_W-1:0] im_sq_c;

  // Full-width signed squares; (-2^15)^2 = 2^30 still fits as a positive value.
  assign re_ext_c = {{DATA_W{s1_re[DATA_W-1]}}, s1_re};
  assign im_ext_c = {{DATA_W{s1_im[DATA_W-1]}}, s1_im};
  assign re_sq_c  = re_ext_c * re_ext_c;
  assign im_sq_c  = im_ext_c * im_ext_c;

  // S1 capture, S2 squares, S3 sum with one guard bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_idx    <= '0;
      s1_re     <= '0;
      s1_im     <= '0;
      s2_valid  <= 1'b0;
      s2_idx    <= '0;
      s2_re_sq  <= '0;
      s2_im_sq  <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_mag   <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_idx    <= in_idx;
      s1_re     <= in_re;
      s1_im     <= in_im;
      s2_valid  <= s1_valid;
      s2_idx    <= s1_idx;
      s2_re_sq  <= $unsigned(re_sq_c);
      s2_im_sq  <= $unsigned(im_sq_c);
      out_valid <= s2_valid;
      out_idx   <= s2_idx;
      out_mag   <= {1'b0, s2_re_sq} + {1'b0, s2_im_sq};
    end
  end

endmodule

// File: rtl/fft_energy_reader.sv
// fft_energy_reader: consumes one FFT frame, accumulates bin energy, flags
// ordering errors and threshold detection.
// Optional peak-bin tracking: define FFT_ENERGY_READER_PEAK_BIN_EN.
module fft_energy_reader #(
  parameter int unsigned DATA_W = fft_reader_pkg::DATA_W,
  parameter int unsigned ADDR_W = fft_reader_pkg::ADDR_W,
  parameter int unsigned ACC_W  = fft_reader_pkg::ACC_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     fft_dv,
  input  logic [ADDR_W-1:0]        fft_xk_index,
  input  logic signed [DATA_W-1:0] fft_xk_re,
  input  logic signed [DATA_W-1:0] fft_xk_im,
  input  logic [ACC_W-1:0]         threshold,
  output logic                     busy,
  output logic [ACC_W-1:0]         energy,
  output logic                     energy_valid,
  output logic                     detect,
  output logic                     index_err,
  output logic [2*DATA_W:0]        peak_mag,
  output logic [ADDR_W-1:0]        peak_idx
);

  import fft_reader_pkg::*;

  localparam int unsigned      MAG_W    = 2 * DATA_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_sum_c;
  logic [ACC_W-1:0]  thr_q, thr_d;
  logic [ADDR_W-1:0] expected_q, expected_d;
  logic              busy_d, energy_valid_d, detect_d, index_err_d;
  logic [ACC_W-1:0]  energy_d;
  logic              feed_c, accept_c, done_c, mag_en_c;
  logic              mag_valid;
  logic [ADDR_W-1:0] mag_idx;
  logic [MAG_W-1:0]  mag;

  mag_sq_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_pipe (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (feed_c),
    .in_idx   (fft_xk_index),
    .in_re    (fft_xk_re),
    .in_im    (fft_xk_im),
    .out_valid(mag_valid),
    .out_idx  (mag_idx),
    .out_mag  (mag)
  );

  // Only beats of the live frame reach the accumulator; leftovers of a dropped frame drain unused.
  assign mag_en_c  = mag_valid && ((state_q == ACCUM) || (state_q == FLUSH));
  assign acc_sum_c = mag_en_c ? acc_q + ACC_W'(mag) : acc_q;

  // Next-state and next-output logic for the frame FSM.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_sum_c;
    thr_d          = thr_q;
    expected_d     = expected_q;
    busy_d         = busy;
    energy_d       = energy;
    energy_valid_d = 1'b0;
    detect_d       = detect;
    index_err_d    = index_err;
    feed_c         = 1'b0;
    accept_c       = 1'b0;
    done_c         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) accept_c = 1'b1;
      end
      WAIT_FIRST: begin
        if (fft_dv && (fft_xk_index == '0)) begin
          feed_c     = 1'b1;
          expected_d = ADDR_W'(1);
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        if (fft_dv) begin
          if (fft_xk_index != expected_q) begin
            index_err_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = IDLE;
          end else begin
            feed_c     = 1'b1;
            expected_d = expected_q + ADDR_W'(1);
            if (fft_xk_index == LAST_IDX) state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (mag_valid && (mag_idx == LAST_IDX)) begin
          done_c         = 1'b1;
          energy_valid_d = 1'b1;
          energy_d       = acc_sum_c;
          detect_d       = (acc_sum_c > thr_q);
          busy_d         = 1'b0;
          state_d        = IDLE;
          if (start) accept_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept_c) begin
      thr_d       = threshold;
      acc_d       = '0;
      expected_d  = '0;
      index_err_d = 1'b0;
      busy_d      = 1'b1;
      state_d     = WAIT_FIRST;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      thr_q        <= '0;
      expected_q   <= '0;
      busy         <= 1'b0;
      energy       <= '0;
      energy_valid <= 1'b0;
      detect       <= 1'b0;
      index_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      thr_q        <= thr_d;
      expected_q   <= expected_d;
      busy         <= busy_d;
      energy       <= energy_d;
      energy_valid <= energy_valid_d;
      detect       <= detect_d;
      index_err    <= index_err_d;
    end
  end

`ifdef FFT_ENERGY_READER_PEAK_BIN_EN
  logic [MAG_W-1:0]  run_mag_q, run_mag_d, peak_mag_d;
  logic [ADDR_W-1:0] run_idx_q, run_idx_d, peak_idx_d;

  // Running maximum; strict compare keeps the lowest index on ties.
  always_comb begin
    run_mag_d  = run_mag_q;
    run_idx_d  = run_idx_q;
    peak_mag_d = peak_mag;
    peak_idx_d = peak_idx;
    if (mag_en_c && (mag > run_mag_q)) begin
      run_mag_d = mag;
      run_idx_d = mag_idx;
    end
    if (done_c) begin
      peak_mag_d = run_mag_d;
      peak_idx_d = run_idx_d;
    end
    if (accept_c) begin
      run_mag_d = '0;
      run_idx_d = '0;
      if (!done_c) begin
        peak_mag_d = '0;
        peak_idx_d = '0;
      end
    end
  end

  // Peak registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_mag_q <= '0;
      run_idx_q <= '0;
      peak_mag  <= '0;
      peak_idx  <= '0;
    end else begin
      run_mag_q <= run_mag_d;
      run_idx_q <= run_idx_d;
      peak_mag  <= peak_mag_d;
      peak_idx  <= peak_idx_d;
    end
  end
`else
  assign peak_mag = '0;
  assign peak_idx = '0;
`endif

endmodule

// File: tb/tb_fft_energy_reader.sv
// Self-checking bench for fft_energy_reader: table of frames plus corner sequences.
module tb_fft_energy_reader;

  localparam int N = 1024;

  logic               clock = 1'b0;
  logic               reset_n, start, fft_dv;
  logic [9:0]         fft_xk_index;
  logic signed [15:0] fft_xk_re, fft_xk_im;
  logic [47:0]        threshold;
  logic               busy, energy_valid, detect, index_err;
  logic [47:0]        energy;
  logic [32:0]        peak_mag;
  logic [9:0]         peak_idx;

  int tests = 0;
  int fails = 0;
  int re_a[N];
  int im_a[N];

  typedef struct {
    bit          rnd;
    int          re;
    int          im;
    int          gap;
    logic [47:0] thr;
    int          thr_off;
    logic [47:0] exp_energy;
    logic        exp_detect;
  } vec_t;

  vec_t tbl[5];

  fft_energy_reader dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .fft_dv      (fft_dv),
    .fft_xk_index(fft_xk_index),
    .fft_xk_re   (fft_xk_re),
    .fft_xk_im   (fft_xk_im),
    .threshold   (threshold),
    .busy        (busy),
    .energy      (energy),
    .energy_valid(energy_valid),
    .detect      (detect),
    .index_err   (index_err),
    .peak_mag    (peak_mag),
    .peak_idx    (peak_idx)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: frame energy is the plain sum of re^2 + im^2 over all bins.
  function automatic logic [47:0] model_energy();
    longint s = 0;
    for (int i = 0; i < N; i++)
      s += longint'(re_a[i]) * longint'(re_a[i]) + longint'(im_a[i]) * longint'(im_a[i]);
    return 48'(s);
  endfunction

  // Reference peak: first bin holding the maximum magnitude (zero when peak logic absent).
  function automatic void model_peak(output longint pm, output int pi);
    longint m;
    pm = 0;
    pi = 0;
    for (int i = 0; i < N; i++) begin
      m = longint'(re_a[i]) * longint'(re_a[i]) + longint'(im_a[i]) * longint'(im_a[i]);
      if (m > pm) begin
        pm = m;
        pi = i;
      end
    end
`ifndef FFT_ENERGY_READER_PEAK_BIN_EN
    pm = 0;
    pi = 0;
`endif
  endfunction

  task automatic fill_const(input int re, input int im);
    for (int i = 0; i < N; i++) begin
      re_a[i] = re;
      im_a[i] = im;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) begin
      re_a[i] = int'($urandom_range(65535)) - 32768;
      im_a[i] = int'($urandom_range(65535)) - 32768;
    end
  endtask

  task automatic beat(input int idx, input int re, input int im);
    fft_dv       = 1'b1;
    fft_xk_index = 10'(idx);
    fft_xk_re    = 16'(re);
    fft_xk_im    = 16'(im);
    @(posedge clock); #1;
    fft_dv = 1'b0;
  endtask

  task automatic do_start(input logic [47:0] thr);
    start     = 1'b1;
    threshold = thr;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // gap: 0 back-to-back, 1 one idle cycle between beats, 2 random 0..2 idle cycles.
  task automatic send_beats(input int gap, input int start_at, input logic [47:0] start_thr);
    int g;
    for (int i = 0; i < N; i++) begin
      g = (gap == 0) ? 0 : (gap == 1) ? 1 : int'($urandom_range(2));
      repeat (g) begin
        @(posedge clock); #1;
      end
      if (i == start_at) begin
        start     = 1'b1;
        threshold = start_thr;
      end
      beat(i, re_a[i], im_a[i]);
      start = 1'b0;
    end
  endtask

  task automatic finish_frame(input string name, input logic [47:0] exp_e, input logic exp_d);
    int     lat = 0;
    int     npulse = 0;
    longint pm;
    int     pi;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock); #1;
      if (energy_valid) begin
        npulse++;
        if (lat == 0) lat = k;
      end
    end
    model_peak(pm, pi);
    check({name, ".latency"}, 64'(lat), 64'(3));
    check({name, ".pulses"}, 64'(npulse), 64'(1));
    check({name, ".energy"}, 64'(energy), 64'(exp_e));
    check({name, ".detect"}, 64'(detect), 64'(exp_d));
    check({name, ".busy"}, 64'(busy), 64'(0));
    check({name, ".index_err"}, 64'(index_err), 64'(0));
    check({name, ".peak_mag"}, 64'(peak_mag), 64'(pm));
    check({name, ".peak_idx"}, 64'(peak_idx), 64'(pi));
  endtask

  task automatic run_frame(input string name, input int gap, input logic [47:0] thr,
                           input logic [47:0] exp_e, input logic exp_d);
    do_start(thr);
    check({name, ".busy_on_start"}, 64'(busy), 64'(1));
    send_beats(gap, -1, '0);
    finish_frame(name, exp_e, exp_d);
  endtask

  initial begin
    int seq[4];
    int npulse;

    reset_n = 1'b0; start = 1'b0; fft_dv = 1'b0; fft_xk_index = '0;
    fft_xk_re = '0; fft_xk_im = '0; threshold = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.energy", 64'(energy), 64'(0));
    check("rst.energy_valid", 64'(energy_valid), 64'(0));
    check("rst.detect", 64'(detect), 64'(0));
    check("rst.index_err", 64'(index_err), 64'(0));
    check("rst.peak_mag", 64'(peak_mag), 64'(0));
    check("rst.peak_idx", 64'(peak_idx), 64'(0));
    reset_n = 1'b1;
    @(posedge clock); #1;

    // dv while idle must not start anything
    beat(0, 7, 7);
    repeat (4) begin
      @(posedge clock); #1;
    end
    check("idle_dv.busy", 64'(busy), 64'(0));
    check("idle_dv.energy_valid", 64'(energy_valid), 64'(0));

    tbl[0] = '{rnd: 1'b0, re: 1,      im: 0,      gap: 0, thr: 48'd1000, thr_off: 0,
               exp_energy: 48'd1024, exp_detect: 1'b1};
    tbl[1] = '{rnd: 1'b0, re: -32768, im: -32768, gap: 1, thr: 48'd0,    thr_off: 0,
               exp_energy: 48'h200_0000_0000, exp_detect: 1'b1};
    tbl[2] = '{rnd: 1'b0, re: 0,      im: 3,      gap: 0, thr: 48'd9216, thr_off: 0,
               exp_energy: 48'd9216, exp_detect: 1'b0};
    tbl[3] = '{rnd: 1'b1, re: 0, im: 0, gap: 2, thr: '0, thr_off: 0, exp_energy: '0, exp_detect: 1'b0};
    tbl[4] = '{rnd: 1'b1, re: 0, im: 0, gap: 0, thr: '0, thr_off: 1, exp_energy: '0, exp_detect: 1'b0};

    for (int i = 0; i < 5; i++) begin
      if (tbl[i].rnd) begin
        fill_rand();
        tbl[i].exp_energy = model_energy();
        tbl[i].thr        = tbl[i].exp_energy - 48'(tbl[i].thr_off);
        tbl[i].exp_detect = tbl[i].exp_energy > tbl[i].thr;
      end else begin
        fill_const(tbl[i].re, tbl[i].im);
      end
      run_frame($sformatf("tbl%0d", i), tbl[i].gap, tbl[i].thr, tbl[i].exp_energy, tbl[i].exp_detect);
    end

    // Sync: beats before index 0 are discarded silently
    fill_const(1, 0);
    do_start(48'd0);
    for (int j = 1020; j < 1024; j++) beat(j, 50, 50);
    check("sync.index_err", 64'(index_err), 64'(0));
    send_beats(0, -1, '0);
    finish_frame("sync", 48'd1024, 1'b1);

    // Ordering error 0,1,2,4
    fill_const(2, 0);
    do_start(48'd0);
    seq = '{0, 1, 2, 4};
    for (int j = 0; j < 3; j++) beat(seq[j], 2, 0);
    check("order.err_before", 64'(index_err), 64'(0));
    beat(seq[3], 2, 0);
    check("order.index_err", 64'(index_err), 64'(1));
    check("order.busy", 64'(busy), 64'(0));
    npulse = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      if (energy_valid) npulse++;
    end
    check("order.no_energy_valid", 64'(npulse), 64'(0));
    do_start(48'd0);
    check("order.err_cleared", 64'(index_err), 64'(0));
    check("order.busy_restart", 64'(busy), 64'(1));
    send_beats(0, -1, '0);
    finish_frame("after_err", 48'd4096, 1'b1);

    // start while busy is ignored; threshold not re-latched
    fill_const(1, 0);
    do_start(48'd5000);
    send_beats(0, 300, 48'd0);
    finish_frame("busy_start", 48'd1024, 1'b0);

    // start coinciding with energy_valid begins the next frame
    fill_const(1, 1);
    do_start(48'd0);
    send_beats(0, -1, '0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("evstart.early", 64'(energy_valid), 64'(0));
    start     = 1'b1;
    threshold = 48'd3000;
    @(posedge clock); #1;
    start = 1'b0;
    check("evstart.energy_valid", 64'(energy_valid), 64'(1));
    check("evstart.energy", 64'(energy), 64'(2048));
    check("evstart.busy", 64'(busy), 64'(1));
    fill_const(0, 2);
    send_beats(1, -1, '0);
    finish_frame("evstart2", 48'd4096, 1'b1);

    // Peak bin: ties keep the lowest index
    fill_const(0, 0);
    re_a[37]  = 100;
    re_a[900] = 100;
    run_frame("peak", 0, 48'd20000, 48'd20000, 1'b0);
`ifdef FFT_ENERGY_READER_PEAK_BIN_EN
    check("peak.mag_const", 64'(peak_mag), 64'(10000));
    check("peak.idx_const", 64'(peak_idx), 64'(37));
`else
    check("peak.mag_off", 64'(peak_mag), 64'(0));
    check("peak.idx_off", 64'(peak_idx), 64'(0));
`endif

    // Asynchronous reset at bin 500 clears everything immediately
    fill_const(1, 0);
    do_start(48'd0);
    for (int j = 0; j < 500; j++) beat(j, 1, 0);
    fft_dv = 1'b1; fft_xk_index = 10'd500;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst.busy", 64'(busy), 64'(0));
    check("arst.energy", 64'(energy), 64'(0));
    check("arst.detect", 64'(detect), 64'(0));
    check("arst.energy_valid", 64'(energy_valid), 64'(0));
    check("arst.index_err", 64'(index_err), 64'(0));
    check("arst.peak_mag", 64'(peak_mag), 64'(0));
    fft_dv = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    run_frame("post_reset", 0, 48'd100, 48'd1024, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft_energy_reader.md
Name: fft_energy_reader

Overview:
Consumer end of the FFT core output port. Accepts one frame of 1024 complex bins (xk_index 0..1023, dv-qualified) and computes |X|^2 per bin through a pipeline. Accumulates total frame energy, checks bin ordering, and compares the energy against a threshold to raise the detection flag. Sits between the FFT core and the detection/reporting logic.

Parameters:
DATA_W, 16, signed width of fft_xk_re / fft_xk_im
ADDR_W, 10, bin index width; frame length N_BINS = 2**ADDR_W
ACC_W, 48, accumulator / energy / threshold width

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; arm the reader for the next frame
fft_dv  in  1  FFT output data valid
fft_xk_index  in  ADDR_W  bin index of the current output sample
fft_xk_re  in  DATA_W  real part, signed
fft_xk_im  in  DATA_W  imaginary part, signed
threshold  in  ACC_W  detection threshold, unsigned; sampled on start
busy  out  1  high from start acceptance until energy_valid
energy  out  ACC_W  frame energy, held until next energy_valid
energy_valid  out  1  one-cycle pulse when energy/detect update
detect  out  1  energy > threshold_latched, held with energy
index_err  out  1  sticky; bin ordering violation, cleared by start
peak_mag  out  2*DATA_W+1  largest |X|^2 of frame (PEAK_BIN_EN)
peak_idx  out  ADDR_W  bin index of peak_mag (PEAK_BIN_EN)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, accumulator 0, expected index 0.
- FSM states: IDLE, WAIT_FIRST, ACCUM, FLUSH.
- IDLE: start -> latch threshold, clear accumulator and index_err, set expected=0, busy=1 -> WAIT_FIRST. fft_dv is ignored in IDLE.
- WAIT_FIRST: discard dv beats with index != 0, with no error. On dv and index==0, feed the pipeline, set expected=1 -> ACCUM.
- ACCUM: each dv beat feeds the pipeline. If index != expected, set index_err=1, drop the frame (no energy_valid, busy->0) and go to IDLE. Otherwise expected++. The beat with index N_BINS-1 goes to FLUSH. Gaps in dv are legal.
- Pipeline: S1 registers re/im; S2 computes re*re and im*im (each 2*DATA_W unsigned); S3 sums them (2*DATA_W+1 bits), zero-extends and adds into the accumulator.
- FLUSH: wait for the last beat to leave S3. energy_valid pulses exactly 3 cycles after the dv beat with index 1023. energy <= acc and detect <= (acc > threshold_latched) update on the same edge. busy drops on that edge, then IDLE.
- Accumulator wraps modulo 2**ACC_W with no saturation. Defaults cannot overflow: 1024*2^31 < 2^48.
- Boundaries:
  - start while busy is ignored.
  - start in the same cycle as energy_valid is accepted (FSM already in IDLE semantics on that edge).
  - reset_n low mid-frame clears everything immediately and aborts the frame silently.
  - Extreme input re=im=-32768 gives a square sum of 2^31, no overflow at 2*DATA_W+1 bits.

Optional Feature:
Macro FFT_ENERGY_READER_PEAK_BIN_EN.
- Defined: tracks the maximum S3 magnitude per frame and its index. Strictly greater replaces, so ties keep the lowest index. peak_mag/peak_idx update with energy_valid and are cleared on start.
- Undefined: no peak logic; peak_mag and peak_idx are tied to 0.

Decomposition:
- Package fft_reader_pkg holds: ADDR_W/N_BINS constants, FSM state encoding (IDLE=0, WAIT_FIRST=1, ACCUM=2, FLUSH=3), LAST_BIN = N_BINS-1.
- One sub-module, mag_sq_pipe, implements S1–S3 (re/im in, dv/index in, |X|^2 out with matching valid/index, 3-cycle latency). Reuse it for any other magnitude path.

Test Plan:
- Basic frame: start; 1024 consecutive beats re=1, im=0; threshold=1000 -> energy=1024, detect=1, energy_valid pulses exactly 3 cycles after index 1023, busy then 0.
- Gapped and extreme frame: dv toggling every other cycle; re=-32768, im=-32768 on all bins -> energy=1024*2^31=2^41, no error.
- Sync: start, then beats with index 1020..1023 before index 0 -> those beats ignored, index_err=0, energy covers bins 0..1023 only.
- Ordering error: index sequence 0,1,2,4 -> index_err=1 after the 4th beat, no energy_valid, busy=0; next start clears index_err.
- Reset and re-start: reset_n low at bin 500 -> all outputs 0 asynchronously; start while busy is ignored (threshold not re-latched); start in the energy_valid cycle begins a new frame.
- PEAK_BIN_EN: bin 37 re=100, bin 900 re=100, others 0 -> peak_mag=10000, peak_idx=37. Without the macro, both outputs stay 0.
